// File: rtl/evm_pkg.sv
// evm_pkg: shared constants and types for the electronic voting machine.
//   - party index constants (P1, P2, P3) and party count
//   - count widths for the per-party/per-gender tallies and the total
//   - leader encoding used when EVM_LEADER_EN is defined
package evm_pkg;

    localparam int unsigned NUM_PARTIES = 3;

    localparam int unsigned P1 = 0;
    localparam int unsigned P2 = 1;
    localparam int unsigned P3 = 2;

    localparam int unsigned TALLY_W = 8;
    localparam int unsigned TOTAL_W = 7;

    typedef enum logic [1:0] {
        LeaderNone = 2'd0,
        LeaderP1   = 2'd1,
        LeaderP2   = 2'd2,
        LeaderP3   = 2'd3
    } leader_e;

endpackage

// File: rtl/evm_percent.sv
// evm_percent: combinational turnout percentage, floor(dout * 100 / NUM_VOTERS).
// Ports:
//   dout              in   total accepted votes
//   voting_percentage out  0..100, truncated (no rounding)
module evm_percent
    import evm_pkg::*;
#(
    parameter int unsigned NUM_VOTERS = 127
) (
    input  logic [TOTAL_W-1:0] dout,
    output logic [TALLY_W-1:0] voting_percentage
);

    // 127 * 100 = 12700 fits in 14 bits.
    localparam int unsigned PROD_W = 14;

    logic [PROD_W-1:0] scaled;

    assign scaled            = PROD_W'(dout) * PROD_W'(100);
    assign voting_percentage = TALLY_W'(scaled / PROD_W'(NUM_VOTERS));

endmodule

// File: rtl/electronic_voting_machine.sv
// electronic_voting_machine: three-party voting core with per-party and per-gender
// tallies, total count, turnout percentage and per-party confirmation LEDs.
// At most one vote is accepted per assertion of voting_en.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   voter_switch[2:0]          one-hot ballot (bit0 party1 .. bit2 party3)
//   voting_en                  booth open for one voter
//   gender_in_male/female      voter gender, exactly one must be high
//   opled1..3                  vote-accepted LEDs, held until voting_en drops
//   invalid                    registered malformed/rejected-ballot flag
//   dout                       total accepted votes (capped at NUM_VOTERS)
//   party1..3                  per-party tallies
//   gender_out_male/female     per-gender tallies
//   voting_percentage          floor(dout*100/NUM_VOTERS)
//   one_twenty_seven           constant NUM_VOTERS
//   leader                     (only with EVM_LEADER_EN) party with strictly highest tally
module electronic_voting_machine
    import evm_pkg::*;
#(
    parameter int unsigned NUM_VOTERS = 127
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         voter_switch,
    input  logic               voting_en,
    input  logic               gender_in_male,
    input  logic               gender_in_female,
    output logic               opled1,
    output logic               opled2,
    output logic               opled3,
    output logic               invalid,
    output logic [TOTAL_W-1:0] dout,
    output logic [TALLY_W-1:0] party1,
    output logic [TALLY_W-1:0] party2,
    output logic [TALLY_W-1:0] party3,
    output logic [TALLY_W-1:0] gender_out_male,
    output logic [TALLY_W-1:0] gender_out_female,
    output logic [TALLY_W-1:0] voting_percentage,
`ifdef EVM_LEADER_EN
    output logic [1:0]         leader,
`endif
    output logic [TOTAL_W-1:0] one_twenty_seven
);

    logic [NUM_PARTIES-1:0][TALLY_W-1:0] tally_q, tally_d;
    logic [TALLY_W-1:0]                  male_q, male_d;
    logic [TALLY_W-1:0]                  female_q, female_d;
    logic [TOTAL_W-1:0]                  dout_q, dout_d;
    logic [NUM_PARTIES-1:0]              led_q, led_d;
    logic                                voted_q, voted_d;
    logic                                invalid_q, invalid_d;

    logic one_hot;
    logic gender_ok;
    logic full;
    logic ballot_ok;

    assign one_hot   = (voter_switch == 3'b001) || (voter_switch == 3'b010) ||
                       (voter_switch == 3'b100);
    assign gender_ok = gender_in_male ^ gender_in_female;
    assign full      = (dout_q >= TOTAL_W'(NUM_VOTERS));
    // voted is deliberately not part of this: a repeat press is ignored silently.
    assign ballot_ok = one_hot & gender_ok & ~full;

    always_comb begin
        tally_d   = tally_q;
        male_d    = male_q;
        female_d  = female_q;
        dout_d    = dout_q;
        led_d     = led_q;
        voted_d   = voted_q;
        invalid_d = voting_en & ~ballot_ok;

        if (!voting_en) begin
            voted_d = 1'b0;
            led_d   = '0;
        end else if (ballot_ok && !voted_q) begin
            // voter_switch is one-hot here, so exactly one party increments.
            for (int i = 0; i < NUM_PARTIES; i++) begin
                if (voter_switch[i]) begin
                    tally_d[i] = tally_q[i] + TALLY_W'(1);
                    led_d[i]   = 1'b1;
                end
            end
            if (gender_in_male) begin
                male_d = male_q + TALLY_W'(1);
            end else begin
                female_d = female_q + TALLY_W'(1);
            end
            dout_d  = dout_q + TOTAL_W'(1);
            voted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tally_q   <= '0;
            male_q    <= '0;
            female_q  <= '0;
            dout_q    <= '0;
            led_q     <= '0;
            voted_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            tally_q   <= tally_d;
            male_q    <= male_d;
            female_q  <= female_d;
            dout_q    <= dout_d;
            led_q     <= led_d;
            voted_q   <= voted_d;
            invalid_q <= invalid_d;
        end
    end

    assign opled1            = led_q[P1];
    assign opled2            = led_q[P2];
    assign opled3            = led_q[P3];
    assign invalid           = invalid_q;
    assign dout              = dout_q;
    assign party1            = tally_q[P1];
    assign party2            = tally_q[P2];
    assign party3            = tally_q[P3];
    assign gender_out_male   = male_q;
    assign gender_out_female = female_q;
    assign one_twenty_seven  = TOTAL_W'(NUM_VOTERS);

    evm_percent #(
        .NUM_VOTERS(NUM_VOTERS)
    ) u_percent (
        .dout             (dout_q),
        .voting_percentage(voting_percentage)
    );

`ifdef EVM_LEADER_EN
    leader_e leader_w;

    // Ties (including all-zero) report no leader.
    always_comb begin
        leader_w = LeaderNone;
        if (tally_q[P1] > tally_q[P2] && tally_q[P1] > tally_q[P3]) begin
            leader_w = LeaderP1;
        end else if (tally_q[P2] > tally_q[P1] && tally_q[P2] > tally_q[P3]) begin
            leader_w = LeaderP2;
        end else if (tally_q[P3] > tally_q[P1] && tally_q[P3] > tally_q[P2]) begin
            leader_w = LeaderP3;
        end
    end

    assign leader = leader_w;
`endif

endmodule

// File: tb/tb_electronic_voting_machine.sv
// Self-checking bench for electronic_voting_machine: a reference model predicts the
// outputs for every clocked input vector, the prediction is queued, and the queue is
// popped and compared against the DUT one time unit after the following rising edge.
module tb_electronic_voting_machine;

`ifdef EVM_LEADER_EN
    localparam int OBS_W = 68;
`else
    localparam int OBS_W = 66;
`endif
    localparam int unsigned NV = 127;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] voter_switch = 3'b000;
    logic       voting_en = 1'b0;
    logic       gender_in_male = 1'b0;
    logic       gender_in_female = 1'b0;
    logic       opled1, opled2, opled3, invalid;
    logic [6:0] dout, one_twenty_seven;
    logic [7:0] party1, party2, party3, gender_out_male, gender_out_female;
    logic [7:0] voting_percentage;
`ifdef EVM_LEADER_EN
    logic [1:0] leader;
`endif

    electronic_voting_machine #(.NUM_VOTERS(NV)) dut (
        .clk              (clk),
        .rst              (rst),
        .voter_switch     (voter_switch),
        .voting_en        (voting_en),
        .gender_in_male   (gender_in_male),
        .gender_in_female (gender_in_female),
        .opled1           (opled1),
        .opled2           (opled2),
        .opled3           (opled3),
        .invalid          (invalid),
        .dout             (dout),
        .party1           (party1),
        .party2           (party2),
        .party3           (party3),
        .gender_out_male  (gender_out_male),
        .gender_out_female(gender_out_female),
        .voting_percentage(voting_percentage),
`ifdef EVM_LEADER_EN
        .leader           (leader),
`endif
        .one_twenty_seven (one_twenty_seven)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int   m_p [3];
    int   m_male, m_female, m_dout;
    logic m_voted;
    logic [2:0] m_led;
    logic m_inv;

    logic [OBS_W-1:0] sb [$];

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_p[i] = 0;
        m_male = 0; m_female = 0; m_dout = 0;
        m_voted = 1'b0; m_led = 3'b000; m_inv = 1'b0;
    endfunction

    function automatic void model_step(logic [2:0] sw, logic en, logic ml, logic fe);
        logic ok;
        ok = ($countones(sw) == 1) && (ml != fe) && (m_dout < NV);
        if (!en) begin
            m_inv = 1'b0; m_voted = 1'b0; m_led = 3'b000;
        end else begin
            m_inv = !ok;
            if (ok && !m_voted) begin
                for (int i = 0; i < 3; i++) begin
                    if (sw[i]) begin
                        m_p[i]++;
                        m_led[i] = 1'b1;
                    end
                end
                if (ml) m_male++; else m_female++;
                m_dout++;
                m_voted = 1'b1;
            end
        end
    endfunction

    function automatic logic [OBS_W-1:0] expected_obs();
        logic [OBS_W-1:0] v;
        v = {m_led[2], m_led[1], m_led[0], m_inv, 7'(m_dout), 8'(m_p[0]), 8'(m_p[1]),
             8'(m_p[2]), 8'(m_male), 8'(m_female), 8'((m_dout * 100) / NV), 7'(NV)
`ifdef EVM_LEADER_EN
             , (m_p[0] > m_p[1] && m_p[0] > m_p[2]) ? 2'd1 :
               (m_p[1] > m_p[0] && m_p[1] > m_p[2]) ? 2'd2 :
               (m_p[2] > m_p[0] && m_p[2] > m_p[1]) ? 2'd3 : 2'd0
`endif
            };
        return v;
    endfunction

    function automatic logic [OBS_W-1:0] observe();
        return {opled3, opled2, opled1, invalid, dout, party1, party2, party3,
                gender_out_male, gender_out_female, voting_percentage, one_twenty_seven
`ifdef EVM_LEADER_EN
                , leader
`endif
               };
    endfunction

    // Drive one clocked input vector and queue the model's prediction for it.
    task automatic cycle(input logic [5:0] vec);
        voter_switch     = vec[5:3];
        voting_en        = vec[2];
        gender_in_male   = vec[1];
        gender_in_female = vec[0];
        model_step(vec[5:3], vec[2], vec[1], vec[0]);
        sb.push_back(expected_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        sb.delete();
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [OBS_W-1:0] exp, got;
        @(posedge clk); #1;
        apply_reset();
        exp = expected_obs(); got = observe(); n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL reset_state got=%h exp=%h", got, exp);
        end
        // Reset mid-session with a lit LED, then a fresh vote right after release.
        cycle(6'b001_1_10);
        exp = sb.pop_front(); got = observe(); n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL reset_pre_vote got=%h exp=%h", got, exp);
        end
        rst = 1'b1; model_reset(); sb.delete(); #1;
        exp = expected_obs(); got = observe(); n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL reset_mid_session got=%h exp=%h", got, exp);
        end
        #1; rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(i == 0 ? 6'b001_1_10 : 6'b000_0_00);
            exp = sb.pop_front(); got = observe(); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL reset_revote c%0d got=%h exp=%h", i, got, exp);
            end
        end
        apply_reset();
    endtask

    task automatic test_single_vote();
        logic [OBS_W-1:0] exp, got;
        logic [5:0] seq [$] = '{6'b001_1_10, 6'b001_1_10, 6'b001_1_10, 6'b001_1_10,
                                6'b001_1_10, 6'b001_0_10};
        foreach (seq[i]) begin
            cycle(seq[i]);
            exp = sb.pop_front(); got = observe(); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL single_vote c%0d got=%h exp=%h", i, got, exp);
            end
        end
        n_cmp++;
        if (party1 !== 8'd1 || dout !== 7'd1 || voting_percentage !== 8'd0 || opled1 !== 1'b0)
        begin
            n_err++;
            $display("FAIL single_vote_final got p1=%0d dout=%0d pct=%0d led=%b exp 1/1/0/0",
                     party1, dout, voting_percentage, opled1);
        end
    endtask

    task automatic test_one_per_session();
        logic [OBS_W-1:0] exp, got;
        logic [5:0] seq [$] = '{6'b010_1_01, 6'b000_1_01, 6'b010_1_01, 6'b100_1_01,
                                6'b000_0_00};
        foreach (seq[i]) begin
            cycle(seq[i]);
            exp = sb.pop_front(); got = observe(); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL one_per_session c%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_malformed();
        logic [OBS_W-1:0] exp, got;
        logic [5:0] seq [$] = '{6'b011_1_10, 6'b111_1_01, 6'b011_0_10, 6'b100_1_11,
                                6'b100_1_00, 6'b100_1_10, 6'b100_1_10, 6'b000_0_00};
        foreach (seq[i]) begin
            cycle(seq[i]);
            exp = sb.pop_front(); got = observe(); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL malformed c%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_full();
        logic [OBS_W-1:0] exp, got;
        logic [5:0] vec;
        apply_reset();
        for (int s = 0; s < NV; s++) begin
            vec = {3'b001 << (s % 3), 1'b1, (s % 2 == 0) ? 2'b10 : 2'b01};
            for (int c = 0; c < 2; c++) begin
                cycle(c == 0 ? vec : 6'b000_0_00);
                exp = sb.pop_front(); got = observe(); n_cmp++;
                if (got !== exp) begin
                    n_err++; $display("FAIL fill s%0d c%0d got=%h exp=%h", s, c, got, exp);
                end
            end
        end
        n_cmp++;
        if (dout !== 7'd127 || voting_percentage !== 8'd100) begin
            n_err++;
            $display("FAIL full_count got dout=%0d pct=%0d exp 127/100", dout,
                     voting_percentage);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(c < 2 ? 6'b010_1_10 : 6'b000_0_00);
            exp = sb.pop_front(); got = observe(); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL over_cap c%0d got=%h exp=%h", c, got, exp);
            end
        end
        // Reset asserted mid-session clears everything at once.
        voting_en = 1'b1; voter_switch = 3'b001; gender_in_male = 1'b1; gender_in_female = 1'b0;
        #2;
        rst = 1'b1; model_reset(); sb.delete(); #1;
        exp = expected_obs(); got = observe(); n_cmp++;
        if (got !== exp || one_twenty_seven !== 7'd127) begin
            n_err++; $display("FAIL full_reset got=%h exp=%h", got, exp);
        end
        #1; rst = 1'b0;
        cycle(6'b000_0_00);
        exp = sb.pop_front(); got = observe(); n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL after_reset got=%h exp=%h", got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_vote();
        test_one_per_session();
        test_malformed();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
